// File: rtl/ec_pkg.sv
// Shared FSM states, field constants and modular helpers
// for the projective elliptic-curve multiple generator.
package ec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Prime field and curve coefficient a of y^2 = x^3 + a*x + b
    localparam int unsigned FIELD_P = 251;
    localparam int unsigned CURVE_A = 0;
    localparam int unsigned INF_Z   = 0;

    typedef logic [31:0] fe_t;

    function automatic int pt_w(input int n);
        return 3 * n;
    endfunction

    function automatic fe_t f_add(input fe_t a, input fe_t b);
        return fe_t'((33'(a) + 33'(b)) % 33'(FIELD_P));
    endfunction

    function automatic fe_t f_sub(input fe_t a, input fe_t b);
        return f_add(a, fe_t'(FIELD_P) - b);
    endfunction

    function automatic fe_t f_mul(input fe_t a, input fe_t b);
        return fe_t'((64'(a) * 64'(b)) % 64'(FIELD_P));
    endfunction

endpackage

// File: rtl/ec_point_ops.sv
// Combinational projective point operators over the prime field.
// Inputs are expected already reduced below FIELD_P.
module PointDouble import ec_pkg::*; #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic [N-1:0] i_z,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y,
    output logic [N-1:0] o_z
);
    fe_t w_x, w_y, w_z, w_w, w_s, w_b, w_h, w_ss;

    always_comb begin
        w_x  = fe_t'(i_x);
        w_y  = fe_t'(i_y);
        w_z  = fe_t'(i_z);
        w_w  = f_add(f_mul(fe_t'(CURVE_A), f_mul(w_z, w_z)),
                     f_mul(32'd3, f_mul(w_x, w_x)));
        w_s  = f_mul(w_y, w_z);
        w_b  = f_mul(f_mul(w_x, w_y), w_s);
        w_h  = f_sub(f_mul(w_w, w_w), f_mul(32'd8, w_b));
        w_ss = f_mul(w_s, w_s);
        o_x  = N'(f_mul(f_mul(32'd2, w_h), w_s));
        o_y  = N'(f_sub(f_mul(w_w, f_sub(f_mul(32'd4, w_b), w_h)),
                        f_mul(32'd8, f_mul(f_mul(w_y, w_y), w_ss))));
        o_z  = N'(f_mul(32'd8, f_mul(w_ss, w_s)));
    end
endmodule

module pointAddition import ec_pkg::*; #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_x1,
    input  logic [N-1:0] i_y1,
    input  logic [N-1:0] i_z1,
    input  logic [N-1:0] i_x2,
    input  logic [N-1:0] i_y2,
    input  logic [N-1:0] i_z2,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y,
    output logic [N-1:0] o_z
);
    fe_t w_u2, w_v2, w_u, w_v, w_w, w_vv, w_vvv, w_a;

    // Equal x coordinates give v=0, so P + (-P) lands on z=0
    always_comb begin
        w_u2  = f_mul(fe_t'(i_y1), fe_t'(i_z2));
        w_v2  = f_mul(fe_t'(i_x1), fe_t'(i_z2));
        w_u   = f_sub(f_mul(fe_t'(i_y2), fe_t'(i_z1)), w_u2);
        w_v   = f_sub(f_mul(fe_t'(i_x2), fe_t'(i_z1)), w_v2);
        w_w   = f_mul(fe_t'(i_z1), fe_t'(i_z2));
        w_vv  = f_mul(w_v, w_v);
        w_vvv = f_mul(w_vv, w_v);
        w_a   = f_sub(f_sub(f_mul(f_mul(w_u, w_u), w_w), w_vvv),
                      f_mul(32'd2, f_mul(w_vv, w_v2)));
        o_x   = N'(f_mul(w_v, w_a));
        o_y   = N'(f_sub(f_mul(w_u, f_sub(f_mul(w_vv, w_v2), w_a)),
                         f_mul(w_vvv, w_u2)));
        o_z   = N'(f_mul(w_vvv, w_w));
    end
endmodule

// File: rtl/ec_step.sv
// One sequence step: reload G after infinity, first doubling,
// then repeated G + acc additions.
module ec_step import ec_pkg::*; #(
    parameter  int N  = 8,
    localparam int PW = pt_w(N)
) (
    input  logic [PW-1:0] i_acc,
    input  logic [PW-1:0] i_g,
    input  logic          i_dbl_sel,
    output logic [PW-1:0] o_next,
    output logic          o_dbl_sel
);
    logic [N-1:0] w_ax, w_ay, w_az;
    logic [N-1:0] w_gx, w_gy, w_gz;
    logic [N-1:0] w_dx, w_dy, w_dz;
    logic [N-1:0] w_sx, w_sy, w_sz;

    assign {w_ax, w_ay, w_az} = i_acc;
    assign {w_gx, w_gy, w_gz} = i_g;

    PointDouble #(.N(N)) u_dbl (
        .i_x(w_ax), .i_y(w_ay), .i_z(w_az),
        .o_x(w_dx), .o_y(w_dy), .o_z(w_dz)
    );

    pointAddition #(.N(N)) u_add (
        .i_x1(w_gx), .i_y1(w_gy), .i_z1(w_gz),
        .i_x2(w_ax), .i_y2(w_ay), .i_z2(w_az),
        .o_x(w_sx), .o_y(w_sy), .o_z(w_sz)
    );

    always_comb begin
        o_next    = {w_sx, w_sy, w_sz};
        o_dbl_sel = 1'b0;
        if (w_az == N'(INF_Z)) begin
            o_next    = i_g;
            o_dbl_sel = 1'b1;
        end else if (i_dbl_sel) begin
            o_next = {w_dx, w_dy, w_dz};
        end
    end
endmodule

// File: rtl/ec_multiple_gen.sv
// Streams 1*G .. C*G (or only C*G) over a valid/ready port,
// with start/done handshake and saturating count.
module ec_multiple_gen import ec_pkg::*; #(
    parameter int N          = 8,
    parameter int MAX_POINTS = 16,
    parameter int CW         = $clog2(MAX_POINTS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          final_only,
    input  logic [N-1:0]  gx,
    input  logic [N-1:0]  gy,
    input  logic [N-1:0]  gz,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_x,
    output logic [N-1:0]  out_y,
    output logic [N-1:0]  out_z,
    output logic [CW-1:0] out_k,
    output logic          out_last,
    output logic          done
);
    localparam int PW = pt_w(N);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_acc_x, r_acc_y, r_acc_z;
    logic [N-1:0]  r_g_x, r_g_y, r_g_z;
    logic [CW-1:0] r_c, r_k;
    logic          r_dbl, r_final, r_done;
    logic [CW-1:0] w_cnt;
    logic [PW-1:0] w_next;
    logic          w_dbl_next, w_last;

    assign w_cnt  = (count > CW'(MAX_POINTS)) ? CW'(MAX_POINTS) : count;
    assign w_last = (r_k == r_c);

    ec_step #(.N(N)) u_step (
        .i_acc    ({r_acc_x, r_acc_y, r_acc_z}),
        .i_g      ({r_g_x, r_g_y, r_g_z}),
        .i_dbl_sel(r_dbl),
        .o_next   (w_next),
        .o_dbl_sel(w_dbl_next)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && w_cnt != '0)
                    w_state_nxt = (!final_only || w_cnt == CW'(1)) ? EMIT : COMPUTE;
            end
            COMPUTE: begin
                if (!r_final || (r_k + CW'(1)) == r_c)
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                if (out_ready)
                    w_state_nxt = w_last ? IDLE : COMPUTE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_acc_x, r_acc_y, r_acc_z} <= '0;
            {r_g_x, r_g_y, r_g_z}       <= '0;
            r_c     <= '0;
            r_k     <= '0;
            r_dbl   <= 1'b0;
            r_final <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start && w_cnt == '0) begin
                        r_done <= 1'b1;
                    end else if (start) begin
                        {r_acc_x, r_acc_y, r_acc_z} <= {gx, gy, gz};
                        {r_g_x, r_g_y, r_g_z}       <= {gx, gy, gz};
                        r_c     <= w_cnt;
                        r_k     <= CW'(1);
                        r_dbl   <= 1'b1;
                        r_final <= final_only;
                    end
                end
                COMPUTE: begin
                    {r_acc_x, r_acc_y, r_acc_z} <= w_next;
                    r_k   <= r_k + CW'(1);
                    r_dbl <= w_dbl_next;
                end
                EMIT: begin
                    if (out_ready && w_last) r_done <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != IDLE);
        out_valid = (r_state == EMIT);
        out_last  = (r_state == EMIT) && w_last;
        out_x     = r_acc_x;
        out_y     = r_acc_y;
        out_z     = r_acc_z;
        out_k     = r_k;
        done      = r_done;
    end
endmodule
